// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: FSM state encoding and default geometry.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CSUM,
    DONE
  } load_state_t;

  localparam int          DEFAULT_DEPTH      = 1024;
  localparam logic [15:0] DEFAULT_START_ADDR = 16'h0000;
  localparam int          HEADER_BYTES       = 2;

endpackage

// File: rtl/bram_loader_if.sv
// Byte-stream input and BRAM port-B write bus of the program loader.
interface bram_loader_if #(
  parameter int ADDR_W = 16
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       data_b;
  logic [ADDR_W-1:0] addr_b;
  logic              we_b;

  modport master (
    input  in_data, in_valid,
    output in_ready, data_b, addr_b, we_b
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, data_b, addr_b, we_b
  );

endinterface

// File: rtl/loader_word_asm.sv
// Packs a big-endian hi/lo byte pair into a 16-bit word; word_valid pulses the cycle after the low byte.
module loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_en,
  input  logic        lo_en,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0] hi_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_byte    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= lo_en;
      if (hi_en) hi_byte <= byte_in;
      if (lo_en) word <= {hi_byte, byte_in};
    end
  end

endmodule

// File: rtl/bram_loader.sv
// Program loader: length-prefixed byte stream -> sequential 16-bit BRAM port-B writes, CPU held meanwhile.
// Optional trailing XOR checksum byte when BRAM_LOADER_CHECKSUM_EN is defined.
module bram_loader
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEFAULT_START_ADDR),
  parameter int                DEPTH      = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  bram_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

`ifdef BRAM_LOADER_CHECKSUM_EN
  localparam load_state_t LAST_STATE = CSUM;
`else
  localparam load_state_t LAST_STATE = DONE;
`endif
  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH);

  load_state_t       state, state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       remaining;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       word;
  logic              word_valid;
  logic              in_ready;
  logic              accept;
  logic              idle_like;
  logic [15:0]       length_full;
  logic              too_long;
`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept      = bus.in_valid && in_ready;
  assign idle_like   = (state == IDLE) || (state == DONE);
  assign length_full = {len_hi, bus.in_data};
  assign too_long    = {1'b0, length_full} > DEPTH_LIMIT;

  loader_word_asm u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .hi_en      (accept && (state == DATA_HI)),
    .lo_en      (accept && (state == DATA_LO)),
    .byte_in    (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = LEN_HI;
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (too_long)               state_nxt = IDLE;
          else if (length_full == '0) state_nxt = LAST_STATE;
          else                        state_nxt = DATA_HI;
        end
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (accept) state_nxt = WRITE;
      end
      WRITE: state_nxt = (remaining == 16'd1) ? LAST_STATE : DATA_HI;
`ifdef BRAM_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        if (accept) state_nxt = (bus.in_data == csum) ? DONE : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = !idle_like;
  assign cpu_hold     = !idle_like;
  assign bus.in_ready = in_ready;
  assign bus.we_b     = (state == WRITE) && word_valid;
  assign bus.addr_b   = addr;
  assign bus.data_b   = word;

  // done is registered so it appears only on the first DONE cycle, not while parked there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_hi    <= '0;
      remaining <= '0;
      addr      <= START_ADDR;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef BRAM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE) && (state != DONE);
      if (idle_like && start) begin
        error <= 1'b0;
        addr  <= START_ADDR;
`ifdef BRAM_LOADER_CHECKSUM_EN
        csum  <= '0;
`endif
      end
      if (accept && (state == LEN_HI)) len_hi <= bus.in_data;
      if (accept && (state == LEN_LO)) begin
        remaining <= length_full;
        if (too_long) error <= 1'b1;
      end
      if (state == WRITE) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - 16'd1;
      end
`ifdef BRAM_LOADER_CHECKSUM_EN
      if (accept && ((state == DATA_HI) || (state == DATA_LO))) csum <= csum ^ bus.in_data;
      if (accept && (state == CSUM) && (bus.in_data != csum)) error <= 1'b1;
`endif
    end
  end

endmodule
